// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game controller.
package simon_pkg;

  localparam int LVL_W         = 4;  // width of level and mem_addr
  localparam int COL_W         = 2;  // width of a colour index
  localparam int MAX_LEVEL_DEF = 9;  // default last playable level

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    HOLD,
    WAIT_IN,
    NEXT,
    WIN,
    LOSE
  } state_t;

  // Decoded view of the four press pulses.
  typedef struct packed {
    logic             valid;  // at least one button pressed
    logic             multi;  // more than one button pressed
    logic [COL_W-1:0] idx;    // colour index of the pressed button
  } btn_code_t;

endpackage

// File: rtl/simon_ctrl_if.sv
// Game-side signal bundle of the Simon controller.
// master: the surroundings (buttons, blink engine, sequence ROM).
// slave : the controller itself.
interface simon_ctrl_if;
  import simon_pkg::*;

  logic             start;
  logic [3:0]       btn;
  logic             blink_done;
  logic [COL_W-1:0] mem_data;
  logic             blink_on;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] mem_addr;
  logic             win;
  logic             lose;

  modport master (
    output start, btn, blink_done, mem_data,
    input  blink_on, level, mem_addr, win, lose
  );

  modport slave (
    input  start, btn, blink_done, mem_data,
    output blink_on, level, mem_addr, win, lose
  );

endinterface

// File: rtl/simon_ctrl_btn_encode.sv
// Combinational button encoder: flags any press, flags multiple presses,
// and gives the colour index of a single press (bit0 -> 0 .. bit3 -> 3).
module btn_encode
  import simon_pkg::*;
(
  input  logic [3:0] btn,
  output btn_code_t  code
);

  // Encode the press pulses; lowest set bit wins when several are set.
  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    code       = '0;
    code.valid = |btn;
    code.multi = |(btn & (btn - 4'd1));
    for (int i = 3; i >= 0; i--) begin
      if (btn[i]) code.idx = COL_W'(i);
    end
  end

endmodule

// File: rtl/simon_ctrl.sv
// Simon game controller: drives the blink engine through each level, checks
// the player's presses against the sequence ROM and reports win/lose.
// Optional feature: define SIMON_TIMEOUT_EN to lose the game after
// TIMEOUT_CYCLES idle cycles while waiting for input.
module simon_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEVEL      = MAX_LEVEL_DEF,
  parameter int HOLD_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input logic         clk,
  input logic         reset,
  simon_ctrl_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(MAX_LEVEL);

  // The blink engine only handles levels 1..9, and level is four bits wide.
  if (MAX_LEVEL < 1 || MAX_LEVEL > 9 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("simon_ctrl: parameter out of range");
  end

  state_t           state,    state_n;
  logic             on_q,     on_n;
  logic [LVL_W-1:0] level_q,  level_n;
  logic [LVL_W-1:0] addr_q,   addr_n;
  logic             win_q,    win_n;
  logic             lose_q,   lose_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;

`ifdef SIMON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt, to_n;
`endif

  btn_code_t code;

  btn_encode u_btn_encode (
    .btn  (bus.btn),
    .code (code)
  );

  assign bus.blink_on = on_q;
  assign bus.level    = level_q;
  assign bus.mem_addr = addr_q;
  assign bus.win      = win_q;
  assign bus.lose     = lose_q;

  // Next state and next registered outputs.
  always_comb begin
    state_n = state;
    on_n    = on_q;
    level_n = level_q;
    addr_n  = addr_q;
    win_n   = win_q;
    lose_n  = lose_q;
    hold_n  = hold_cnt;
`ifdef SIMON_TIMEOUT_EN
    to_n    = to_cnt;
`endif

    unique case (state)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          state_n = SHOW;
          on_n    = 1'b1;
          level_n = LVL_W'(1);
          addr_n  = '0;
          win_n   = 1'b0;
          lose_n  = 1'b0;
        end
      end

      SHOW: begin
        if (bus.blink_done) begin
          state_n = HOLD;
          hold_n  = '0;
        end
      end

      // Keep the last shown LED lit for HOLD_CYCLES before taking input.
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n = WAIT_IN;
          on_n    = 1'b0;
          addr_n  = '0;
`ifdef SIMON_TIMEOUT_EN
          to_n    = '0;
`endif
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end

      WAIT_IN: begin
        if (code.valid) begin
          if (code.multi || (code.idx != bus.mem_data)) begin
            state_n = LOSE;
            lose_n  = 1'b1;
          end else if (addr_q == level_q - LVL_W'(1)) begin
            state_n = NEXT;
          end else begin
            addr_n = addr_q + LVL_W'(1);
`ifdef SIMON_TIMEOUT_EN
            to_n   = '0;
`endif
          end
        end else begin
`ifdef SIMON_TIMEOUT_EN
          if (to_cnt == TO_LAST) begin
            state_n = LOSE;
            lose_n  = 1'b1;
          end
          if (to_cnt != TO_SAT) to_n = to_cnt + TO_W'(1);
`endif
        end
      end

      // blink_on is already low here, giving the engine its restart gap.
      NEXT: begin
        if (level_q == LVL_MAX) begin
          state_n = WIN;
          win_n   = 1'b1;
        end else begin
          state_n = SHOW;
          on_n    = 1'b1;
          level_n = level_q + LVL_W'(1);
          addr_n  = '0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      on_q     <= 1'b0;
      level_q  <= '0;
      addr_q   <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      hold_cnt <= '0;
`ifdef SIMON_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      state    <= state_n;
      on_q     <= on_n;
      level_q  <= level_n;
      addr_q   <= addr_n;
      win_q    <= win_n;
      lose_q   <= lose_n;
      hold_cnt <= hold_n;
`ifdef SIMON_TIMEOUT_EN
      to_cnt   <= to_n;
`endif
    end
  end

endmodule

// File: tb/tb_simon_ctrl.sv
// Directed bench for simon_ctrl: a cycle-by-cycle game table plus hand
// sequences for loss, timeout and mid-phase reset. A second instance with
// MAX_LEVEL=2 runs in lockstep on the same inputs to exercise the win path.
module tb_simon_ctrl;
  import simon_pkg::*;

  localparam int HOLD = 3;
  localparam int TO   = 20;

  logic clk = 1'b0;
  logic reset;

  simon_ctrl_if bus ();
  simon_ctrl_if bus2 ();

  logic [COL_W-1:0] rom [16];

  assign bus.mem_data    = rom[bus.mem_addr];
  assign bus2.start      = bus.start;
  assign bus2.btn        = bus.btn;
  assign bus2.blink_done = bus.blink_done;
  assign bus2.mem_data   = rom[bus2.mem_addr];

  simon_ctrl #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  simon_ctrl #(.MAX_LEVEL(2), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  // {blink_on, level, mem_addr, win, lose}
  logic [10:0] obs, obs2;
  assign obs  = {bus.blink_on, bus.level, bus.mem_addr, bus.win, bus.lose};
  assign obs2 = {bus2.blink_on, bus2.level, bus2.mem_addr, bus2.win, bus2.lose};

  typedef struct packed {
    logic       start;
    logic [3:0] btn;
    logic       done;
    logic       on;
    logic [3:0] lvl;
    logic [3:0] addr;
    logic       win;
    logic       lose;
    logic       win2;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int s, input int b, input int d, input int on, input int lvl,
                     input int addr, input int w, input int l, input int w2);
    vec_t t;
    t = '{1'(s), 4'(b), 1'(d), 1'(on), 4'(lvl), 4'(addr), 1'(w), 1'(l), 1'(w2)};
    vecs.push_back(t);
  endtask

  // One clock: drive at the falling edge, return 1 ns after the rising edge.
  task automatic cyc(input int r, input int s, input int b, input int d);
    @(negedge clk);
    reset          = 1'(r);
    bus.start      = 1'(s);
    bus.btn        = 4'(b);
    bus.blink_done = 1'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic to_wait_in();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (HOLD) cyc(0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pk(input int on, input int lvl, input int addr,
                                     input int w, input int l);
    logic [10:0] v;
    v = {1'(on), 4'(lvl), 4'(addr), 1'(w), 1'(l)};
    return 32'(v);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 2'd3;
    rom[0] = 2'd2;
    rom[1] = 2'd0;
    rom[2] = 2'd1;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.btn        = 4'd0;
    bus.blink_done = 1'b0;

    //   s  btn d   on lvl addr w  l  w2
    add(1, 0, 0,   1, 1, 0,  0, 0, 0);  // start -> SHOW level 1
    add(0, 0, 0,   1, 1, 0,  0, 0, 0);
    add(0, 0, 0,   1, 1, 0,  0, 0, 0);
    add(0, 0, 0,   1, 1, 0,  0, 0, 0);
    add(0, 0, 0,   1, 1, 0,  0, 0, 0);
    add(0, 0, 1,   1, 1, 0,  0, 0, 0);  // blink_done -> HOLD
    add(0, 0, 0,   1, 1, 0,  0, 0, 0);
    add(0, 0, 0,   1, 1, 0,  0, 0, 0);
    add(0, 0, 0,   0, 1, 0,  0, 0, 0);  // WAIT_IN, blink_on low
    add(0, 4, 0,   0, 1, 0,  0, 0, 0);  // correct last entry -> NEXT
    add(0, 0, 0,   1, 2, 0,  0, 0, 0);  // SHOW level 2
    add(0, 0, 1,   1, 2, 0,  0, 0, 0);
    add(0, 0, 0,   1, 2, 0,  0, 0, 0);
    add(0, 0, 0,   1, 2, 0,  0, 0, 0);
    add(0, 0, 0,   0, 2, 0,  0, 0, 0);
    add(0, 4, 0,   0, 2, 1,  0, 0, 0);  // match, address steps
    add(0, 1, 0,   0, 2, 1,  0, 0, 0);  // match on last -> NEXT
    add(0, 0, 0,   1, 3, 0,  0, 0, 1);  // level 3; MAX_LEVEL=2 copy wins
    add(0, 0, 1,   1, 3, 0,  0, 0, 1);
    add(0, 0, 0,   1, 3, 0,  0, 0, 1);
    add(0, 0, 0,   1, 3, 0,  0, 0, 1);
    add(0, 0, 0,   0, 3, 0,  0, 0, 1);
    add(0, 4, 0,   0, 3, 1,  0, 0, 1);  // rom {2,0,1}
    add(0, 1, 0,   0, 3, 2,  0, 0, 1);
    add(0, 2, 0,   0, 3, 2,  0, 0, 1);  // -> NEXT
    add(0, 0, 0,   1, 4, 0,  0, 0, 1);  // SHOW level 4
    add(1, 0, 0,   1, 4, 0,  0, 0, 0);  // start ignored in SHOW; copy restarts
    add(0, 1, 0,   1, 4, 0,  0, 0, 0);  // btn ignored in SHOW
    add(0, 0, 1,   1, 4, 0,  0, 0, 0);
    add(0, 0, 0,   1, 4, 0,  0, 0, 0);
    add(0, 0, 0,   1, 4, 0,  0, 0, 0);
    add(0, 0, 0,   0, 4, 0,  0, 0, 0);
    add(0, 3, 0,   0, 4, 0,  0, 1, 0);  // two buttons -> LOSE
    add(0, 1, 0,   0, 4, 0,  0, 1, 0);  // btn ignored in LOSE
    add(1, 0, 0,   1, 1, 0,  0, 0, 0);  // restart
    add(0, 0, 1,   1, 1, 0,  0, 0, 0);
    add(0, 0, 0,   1, 1, 0,  0, 0, 0);
    add(0, 0, 0,   1, 1, 0,  0, 0, 0);
    add(0, 0, 0,   0, 1, 0,  0, 0, 0);
    add(0, 8, 0,   0, 1, 0,  0, 1, 0);  // idx 3 vs rom 2 -> LOSE
    add(0, 0, 0,   0, 1, 0,  0, 1, 0);  // lose holds

    // Reset overrides a start pulse.
    cyc(1, 1, 0, 0);
    check("reset_state", 0, 32'(obs), pk(0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0);
    check("reset_state2", 0, 32'(obs2), pk(0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      cyc(0, int'(v.start), int'(v.btn), int'(v.done));
      check("game", i, 32'(obs), pk(v.on, v.lvl, v.addr, v.win, v.lose));
      check("win2", i, 32'(bus2.win), 32'(v.win2));
      if (v.win2) check("win2_blink_off", i, 32'(bus2.blink_on), 32'd0);
    end

    // Mismatch with mem_data=1, btn=1000, then a restart clears lose.
    rom[0] = 2'd1;
    to_wait_in();
    check("wait_in_blink_off", 0, 32'(obs), pk(0, 1, 0, 0, 0));
    cyc(0, 0, 8, 0);
    check("mismatch_lose", 0, 32'(obs), pk(0, 1, 0, 0, 1));
    cyc(0, 1, 0, 0);
    check("restart_clears", 0, 32'(obs), pk(1, 1, 0, 0, 0));

    // Idle input in WAIT_IN.
    cyc(0, 0, 0, 1);
    repeat (HOLD) cyc(0, 0, 0, 0);
    repeat (TO - 1) cyc(0, 0, 0, 0);
    check("idle_before_limit", 0, 32'(obs), pk(0, 1, 0, 0, 0));
    cyc(0, 0, 0, 0);
`ifdef SIMON_TIMEOUT_EN
    check("timeout_lose", 0, 32'(obs), pk(0, 1, 0, 0, 1));
`else
    repeat (100 - TO) cyc(0, 0, 0, 0);
    check("no_timeout", 0, 32'(obs), pk(0, 1, 0, 0, 0));
    cyc(0, 0, 2, 0);
    check("late_press_next", 0, 32'(obs), pk(0, 1, 0, 0, 0));
    cyc(0, 0, 0, 0);
    check("late_press_show", 0, 32'(obs), pk(1, 2, 0, 0, 0));
`endif

    // Reset mid-HOLD, with start and blink_done also asserted.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("hold_blink_on", 0, 32'(bus.blink_on), 32'd1);
    cyc(1, 1, 0, 1);
    check("reset_mid_hold", 0, 32'(obs), pk(0, 0, 0, 0, 0));
    check("reset_mid_hold2", 0, 32'(obs2), pk(0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0);
    check("idle_after_reset", 0, 32'(obs), pk(0, 0, 0, 0, 0));

    // Reset mid-SHOW with blink_done.
    cyc(0, 1, 0, 0);
    check("show_again", 0, 32'(obs), pk(1, 1, 0, 0, 0));
    cyc(1, 0, 0, 1);
    check("reset_mid_show", 0, 32'(obs), pk(0, 0, 0, 0, 0));

    // Reset mid-WAIT_IN with a correct press.
    to_wait_in();
    cyc(1, 0, 2, 0);
    check("reset_mid_wait", 0, 32'(obs), pk(0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0);
    check("idle_after_reset2", 0, 32'(obs), pk(0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
